// File: rtl/twos_comp_adder32.sv
// Registered two's-complement adder with signed-overflow flag.
// Built from 4-bit carry-lookahead groups rippled together. Result and flag
// appear one clock after the operands are sampled.
module twos_comp_adder32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    output logic             overflow,
    output logic [WIDTH-1:0] O
);

    localparam int unsigned NumGroups = WIDTH / 4;

    logic [WIDTH-1:0] bit_g;
    logic [WIDTH-1:0] bit_p;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    logic [WIDTH-1:0] o_q;
    logic             ovf_q;

    assign bit_g = I1 & I2;
    assign bit_p = I1 ^ I2;

    // Each group keeps its carries in its own signals, so the ripple between
    // groups never loops back through a single vector.
    for (genvar gi = 0; gi < NumGroups; gi++) begin : g_cla
        localparam int unsigned Base = 4 * gi;

        logic [3:0] g;
        logic [3:0] p;
        logic       gg;
        logic       pp;
        logic       cin;
        // c_out[i] is the carry out of bit i of this group
        logic [3:0] c_out;

        assign g = bit_g[Base +: 4];
        assign p = bit_p[Base +: 4];

        if (gi == 0) begin : g_cin_lsb
            assign cin = 1'b0;
        end else begin : g_cin_chain
            assign cin = g_cla[gi-1].c_out[3];
        end

        // Group generate/propagate
        assign gg = g[3]
                  | (p[3] & g[2])
                  | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
        assign pp = &p;

        // Lookahead carries, all computed directly from cin
        assign c_out[0] = g[0] | (p[0] & cin);
        assign c_out[1] = g[1]
                        | (p[1] & g[0])
                        | (p[1] & p[0] & cin);
        assign c_out[2] = g[2]
                        | (p[2] & g[1])
                        | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & cin);
        assign c_out[3] = gg | (pp & cin);

        assign sum_d[Base +: 4] = p ^ {c_out[2:0], cin};

        // Signed overflow: carry into MSB differs from carry out of MSB
        if (gi == NumGroups - 1) begin : g_ovf
            assign ovf_d = c_out[3] ^ c_out[2];
        end
    end

    // Result register; reset wins over the operands sampled on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            o_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            o_q   <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign O        = o_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_twos_comp_adder32.sv
// Bench for twos_comp_adder32: driver pushes expected results into a
// scoreboard queue, a monitor pops one per clock and compares.
module tb_twos_comp_adder32;

    localparam longint SMax = 64'sd2147483647;
    localparam longint SMin = -64'sd2147483648;

    logic        clk;
    logic        reset;
    logic [31:0] I1;
    logic [31:0] I2;
    logic        overflow;
    logic [31:0] O;

    typedef struct {
        string       name;
        logic [31:0] o;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_pass;
    int   n_total;

    twos_comp_adder32 #(
        .WIDTH(32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .I1      (I1),
        .I2      (I2),
        .overflow(overflow),
        .O       (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one operand pair for one clock and record what must come out
    task automatic drive(input logic rst, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic eov, input string nm);
        exp_t e;
        @(negedge clk);
        reset = rst;
        I1    = a;
        I2    = b;
        e.name = nm;
        e.o    = eo;
        e.ovf  = eov;
        sb.push_back(e);
    endtask

    // Monitor: every edge produces exactly one result for the last pushed entry
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if ((O !== e.o) || (overflow !== e.ovf)) begin
                    $display("FAIL %s: got O=%08h ovf=%b, required O=%08h ovf=%b",
                             e.name, O, overflow, e.o, e.ovf);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        longint      s;
        logic [31:0] eo;
        logic        eov;

        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        I1      = 32'h1234_5678;
        I2      = 32'h7FFF_FFFF;

        drive(1'b1, 32'h1234_5678, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, "reset0");
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, "reset1");

        drive(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, "neg1_plus_1");
        drive(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, "max_plus_1");
        drive(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, "min_plus_neg1");
        drive(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "min_plus_min");
        drive(1'b0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002, 1'b0, "pipe_5_m3");
        drive(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFB, 1'b0, "pipe_m7_2");
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, "reset_mid");
        drive(1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, "plain_pos");
        drive(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "neg_neg_ok");
        drive(1'b0, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1, "pos_pos_ovf");
        drive(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "max_plus_min");
        drive(1'b0, 32'h0FFF_FFFF, 32'h0000_0001, 32'h1000_0000, 1'b0, "long_carry");

        for (int i = 0; i < 10000; i++) begin
            a   = $urandom;
            b   = $urandom;
            s   = longint'($signed(a)) + longint'($signed(b));
            eo  = s[31:0];
            eov = (s > SMax) || (s < SMin);
            drive(1'b0, a, b, eo, eov, "random");
        end

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d results never observed, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
